// File: rtl/replicate_pkg.sv
// Shared constants, state encoding and widths for the replicate / dereplicate datapaths.
package replicate_pkg;

    localparam int unsigned FIELD_W = 2;
    localparam int unsigned REP     = 3;
    localparam int unsigned DIV_W   = 4;
    localparam int unsigned DW      = FIELD_W * REP;
    localparam int unsigned ACC_W   = DW + DIV_W + 1;
    localparam int unsigned STEP_W  = $clog2(DIV_W);

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StCheck,
        StDone
    } state_e;

endpackage

// File: rtl/slice_compare.sv
// Combinational check that every FIELD_W slice of a dividend equals slice 0.
module slice_compare
    import replicate_pkg::*;
(
    input  logic [DW-1:0] data_i,
    output logic          all_eq_o
);

    always_comb begin
        all_eq_o = 1'b1;
        for (int i = 1; i < REP; i++) begin
            if (data_i[i*FIELD_W +: FIELD_W] != data_i[FIELD_W-1:0]) begin
                all_eq_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/dereplicate.sv
// Rebuilds quot*divisor+rem with a shift-add multiplier and recovers the replicated field.
// Optional DEREPLICATE_REMCHK_EN flags remainders not smaller than a non-zero divisor.
module dereplicate
    import replicate_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DW-1:0]      quot,
    input  logic [DIV_W-1:0]   rem,
    input  logic [DIV_W-1:0]   divisor,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [FIELD_W-1:0] field,
    output logic               pattern_ok,
    output logic               overflow,
`ifdef DEREPLICATE_REMCHK_EN
    output logic               rem_err,
`endif
    output logic               div_zero
);

    state_e              state_q;
    logic [ACC_W-1:0]    acc_q;
    logic [DW-1:0]       quot_q;
    logic [DIV_W-1:0]    div_q;
    logic [STEP_W-1:0]   step_q;
    logic                in_ready_q;
    logic                out_valid_q;
    logic [FIELD_W-1:0]  field_q;
    logic                pattern_ok_q;
    logic                overflow_q;
    logic                div_zero_q;

    logic all_eq;
    logic overflow_c;
    logic div_zero_c;
    logic rem_bad_c;

    slice_compare u_slice_compare (
        .data_i   (acc_q[DW-1:0]),
        .all_eq_o (all_eq)
    );

    assign overflow_c = |acc_q[ACC_W-1:DW];
    assign div_zero_c = (div_q == '0);

`ifdef DEREPLICATE_REMCHK_EN
    logic [DIV_W-1:0] rem_q;
    logic             rem_err_q;
    assign rem_bad_c = !div_zero_c && (rem_q >= div_q);
    assign rem_err   = rem_err_q;
`else
    assign rem_bad_c = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            acc_q        <= '0;
            quot_q       <= '0;
            div_q        <= '0;
            step_q       <= '0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            field_q      <= '0;
            pattern_ok_q <= 1'b0;
            overflow_q   <= 1'b0;
            div_zero_q   <= 1'b0;
`ifdef DEREPLICATE_REMCHK_EN
            rem_q        <= '0;
            rem_err_q    <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        quot_q     <= quot;
                        div_q      <= divisor;
                        acc_q      <= ACC_W'(rem);
                        step_q     <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= StMul;
`ifdef DEREPLICATE_REMCHK_EN
                        rem_q      <= rem;
`endif
                    end
                end
                StMul: begin
                    if (div_q[step_q]) begin
                        acc_q <= acc_q + (ACC_W'(quot_q) << step_q);
                    end
                    step_q <= step_q + 1'b1;
                    if (step_q == STEP_W'(DIV_W - 1)) begin
                        state_q <= StCheck;
                    end
                end
                StCheck: begin
                    field_q      <= acc_q[FIELD_W-1:0];
                    overflow_q   <= overflow_c;
                    div_zero_q   <= div_zero_c;
                    pattern_ok_q <= all_eq && !overflow_c && !div_zero_c && !rem_bad_c;
`ifdef DEREPLICATE_REMCHK_EN
                    rem_err_q    <= rem_bad_c;
`endif
                    state_q      <= StDone;
                end
                StDone: begin
                    // out_valid is a registered view of DONE, so it rises one edge after entry
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign field      = field_q;
    assign pattern_ok = pattern_ok_q;
    assign overflow   = overflow_q;
    assign div_zero   = div_zero_q;

endmodule

// File: tb/tb_dereplicate.sv
// Directed, table-driven bench for dereplicate: vector table plus backpressure and reset sequences.
module tb_dereplicate;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] quot;
    logic [3:0] rem;
    logic [3:0] divisor;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] field;
    logic       pattern_ok;
    logic       overflow;
    logic       div_zero;
`ifdef DEREPLICATE_REMCHK_EN
    logic       rem_err;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dereplicate dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .quot       (quot),
        .rem        (rem),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .field      (field),
        .pattern_ok (pattern_ok),
        .overflow   (overflow),
`ifdef DEREPLICATE_REMCHK_EN
        .rem_err    (rem_err),
`endif
        .div_zero   (div_zero)
    );

    typedef struct {
        logic [5:0] q;
        logic [3:0] d;
        logic [3:0] r;
        logic [1:0] f;
        logic       ok;
        logic       ov;
        logic       dz;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operand triple; returns with the result visible and not yet taken.
    task automatic issue(input vec_t v, input string tag);
        int lat;
        chk({tag, " in_ready_before"}, int'(in_ready), 1);
        in_valid = 1'b1;
        quot     = v.q;
        divisor  = v.d;
        rem      = v.r;
        tick();
        in_valid = 1'b0;
        chk({tag, " in_ready_busy"}, int'(in_ready), 0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk({tag, " latency"}, lat, 6);
        chk({tag, " field"}, int'(field), int'(v.f));
        chk({tag, " pattern_ok"}, int'(pattern_ok), int'(v.ok));
        chk({tag, " overflow"}, int'(overflow), int'(v.ov));
        chk({tag, " div_zero"}, int'(div_zero), int'(v.dz));
    endtask

    task automatic take(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, " out_valid_after_take"}, int'(out_valid), 0);
        chk({tag, " in_ready_after_take"}, int'(in_ready), 1);
    endtask

    initial begin
        vec_t v;
        //             q      d      r      f      ok    ov    dz
        vecs[0]  = '{6'd8,  4'd5,  4'd2,  2'b10, 1'b1, 1'b0, 1'b0};  // 42
        vecs[1]  = '{6'd10, 4'd4,  4'd1,  2'b01, 1'b0, 1'b0, 1'b0};  // 41
        vecs[2]  = '{6'd63, 4'd15, 4'd0,  2'b01, 1'b0, 1'b1, 1'b0};  // 945
        vecs[3]  = '{6'd5,  4'd0,  4'd3,  2'b11, 1'b0, 1'b0, 1'b1};  // div by zero
        vecs[4]  = '{6'd0,  4'd1,  4'd0,  2'b00, 1'b1, 1'b0, 1'b0};  // 0
        vecs[5]  = '{6'd63, 4'd1,  4'd0,  2'b11, 1'b1, 1'b0, 1'b0};  // 63
        vecs[6]  = '{6'd4,  4'd15, 4'd3,  2'b11, 1'b1, 1'b0, 1'b0};  // 63
        vecs[7]  = '{6'd1,  4'd15, 4'd15, 2'b10, 1'b0, 1'b0, 1'b0};  // 30
        vecs[8]  = '{6'd3,  4'd15, 4'd15, 2'b00, 1'b0, 1'b0, 1'b0};  // 60
        vecs[9]  = '{6'd0,  4'd0,  4'd0,  2'b00, 1'b0, 1'b0, 1'b1};  // 0 but dz
        vecs[10] = '{6'd16, 4'd4,  4'd0,  2'b00, 1'b0, 1'b1, 1'b0};  // 64, first overflow
        vecs[11] = '{6'd9,  4'd7,  4'd0,  2'b11, 1'b1, 1'b0, 1'b0};  // 63, last no-overflow
        vecs[12] = '{6'd2,  4'd7,  4'd1,  2'b11, 1'b0, 1'b0, 1'b0};  // 15
        vecs[13] = '{6'd4,  4'd0,  4'd15, 2'b11, 1'b0, 1'b0, 1'b1};  // dz, acc=rem

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        quot      = '0;
        rem       = '0;
        divisor   = '0;
        tick();
        tick();
        chk("reset in_ready", int'(in_ready), 1);
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset field", int'(field), 0);
        chk("reset pattern_ok", int'(pattern_ok), 0);
        chk("reset overflow", int'(overflow), 0);
        chk("reset div_zero", int'(div_zero), 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 14; i++) begin
            issue(vecs[i], $sformatf("vec%0d", i));
            take($sformatf("vec%0d", i));
        end

        // Backpressure: result held 10 cycles while new operands are offered and ignored.
        issue(vecs[0], "hold");
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1;
            quot     = 6'd10;
            divisor  = 4'd4;
            rem      = 4'd1;
            tick();
            chk("hold out_valid", int'(out_valid), 1);
            chk("hold in_ready", int'(in_ready), 0);
            chk("hold field", int'(field), 2);
            chk("hold pattern_ok", int'(pattern_ok), 1);
        end
        in_valid = 1'b0;
        take("hold");
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("hold no_ghost_op", int'(out_valid), 0);
            chk("hold idle_ready", int'(in_ready), 1);
        end

        // Reset during MUL step 2 discards the operation.
        in_valid = 1'b1;
        quot     = 6'd63;
        divisor  = 4'd15;
        rem      = 4'd0;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid in_ready", int'(in_ready), 1);
        chk("rst_mid out_valid", int'(out_valid), 0);
        for (int c = 0; c < 8; c++) begin
            tick();
            chk("rst_mid stays_idle", int'(out_valid), 0);
        end
        v = '{6'd21, 4'd1, 4'd0, 2'b01, 1'b1, 1'b0, 1'b0};
        issue(v, "post_rst");
        take("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
